// File: rtl/pipe_ctrl_if.sv
// Pipeline hazard/status bundle between the datapath (master) and the
// stall/flush sequencer (slave).
interface pipe_ctrl_if #(
   parameter int unsigned REGW = 5
);
   logic            ext_stall;
   logic            br_taken;
   logic            ex_load;
   logic [REGW-1:0] ex_rd;
   logic            id_use_a;
   logic            id_use_b;
   logic [REGW-1:0] id_rs_a;
   logic [REGW-1:0] id_rs_b;
   logic            id_is_md;
   logic            md_done;
   logic            pc_wr;
   logic            if_id_wr;
   logic            id_ex_wr;
   logic            ex_mem_wr;
   logic            mem_wb_wr;
   logic            if_id_flush;
   logic            id_ex_flush;
   logic            md_start;
   logic            md_busy;
   logic            md_err;

   modport master (
      output ext_stall, br_taken, ex_load, ex_rd, id_use_a, id_use_b,
             id_rs_a, id_rs_b, id_is_md, md_done,
      input  pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
             if_id_flush, id_ex_flush, md_start, md_busy, md_err
   );

   modport slave (
      input  ext_stall, br_taken, ex_load, ex_rd, id_use_a, id_use_b,
             id_rs_a, id_rs_b, id_is_md, md_done,
      output pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
             if_id_flush, id_ex_flush, md_start, md_busy, md_err
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect,
// memory wait, and MDU start/done handshake with a timeout watchdog.
module pipe_ctrl #(
   parameter int unsigned REGW   = 5,
   parameter int unsigned MD_TMO = 64,
   parameter int unsigned CNTW   = 7
) (
   input logic        clk,
   input logic        rst_n,
   pipe_ctrl_if.slave bus
);
   typedef enum logic {RUN, MD_WAIT} state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            md_ack_q, md_ack_d;
   logic            md_err_q, md_err_d;

   logic [REGW-1:0] ex_rd, rs_a, rs_b;
   logic            hazard;
   logic            pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr;
   logic            if_id_flush, id_ex_flush, md_start, md_busy;

   assign ex_rd  = bus.ex_rd;
   assign rs_a   = bus.id_rs_a;
   assign rs_b   = bus.id_rs_b;
   assign hazard = bus.ex_load & ((bus.id_use_a & (rs_a == ex_rd)) |
                                  (bus.id_use_b & (rs_b == ex_rd)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= RUN;
         cnt_q    <= '0;
         md_ack_q <= 1'b0;
         md_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         md_ack_q <= md_ack_d;
         md_err_q <= md_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      md_ack_d    = md_ack_q;
      md_err_d    = md_err_q;
      pc_wr       = 1'b1;
      if_id_wr    = 1'b1;
      id_ex_wr    = 1'b1;
      ex_mem_wr   = 1'b1;
      mem_wb_wr   = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      md_start    = 1'b0;
      md_busy     = 1'b0;

      if (!rst_n) begin
         pc_wr     = 1'b0;
         if_id_wr  = 1'b0;
         id_ex_wr  = 1'b0;
         ex_mem_wr = 1'b0;
         mem_wb_wr = 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (bus.ext_stall) begin
                  pc_wr     = 1'b0;
                  if_id_wr  = 1'b0;
                  id_ex_wr  = 1'b0;
                  ex_mem_wr = 1'b0;
                  mem_wb_wr = 1'b0;
               end else begin
                  // md_ack lets the just-completed MD instruction leave ID once
                  md_ack_d = 1'b0;
                  if (bus.br_taken) begin
                     if_id_flush = 1'b1;
                     id_ex_flush = 1'b1;
                  end else if (hazard) begin
                     pc_wr       = 1'b0;
                     if_id_wr    = 1'b0;
                     id_ex_flush = 1'b1;
                  end else if (bus.id_is_md && !md_ack_q) begin
                     md_start    = 1'b1;
                     pc_wr       = 1'b0;
                     if_id_wr    = 1'b0;
                     id_ex_flush = 1'b1;
                     state_d     = MD_WAIT;
                     cnt_d       = '0;
                  end
               end
            end
            MD_WAIT: begin
               md_busy = 1'b1;
               if (bus.ext_stall) begin
                  pc_wr     = 1'b0;
                  if_id_wr  = 1'b0;
                  id_ex_wr  = 1'b0;
                  ex_mem_wr = 1'b0;
                  mem_wb_wr = 1'b0;
               end else begin
                  pc_wr       = 1'b0;
                  if_id_wr    = 1'b0;
                  id_ex_flush = 1'b1;
               end
               // Done and the watchdog are honoured even while memory stalls
               if (bus.md_done) begin
                  state_d  = RUN;
                  cnt_d    = '0;
                  md_ack_d = 1'b1;
               end else if (cnt_q == CNTW'(MD_TMO - 1)) begin
                  md_err_d = 1'b1;
                  state_d  = RUN;
                  cnt_d    = '0;
                  md_ack_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   assign bus.pc_wr       = pc_wr;
   assign bus.if_id_wr    = if_id_wr;
   assign bus.id_ex_wr    = id_ex_wr;
   assign bus.ex_mem_wr   = ex_mem_wr;
   assign bus.mem_wb_wr   = mem_wb_wr;
   assign bus.if_id_flush = if_id_flush;
   assign bus.id_ex_flush = id_ex_flush;
   assign bus.md_start    = md_start;
   assign bus.md_busy     = md_busy;
   assign bus.md_err      = md_err_q;
endmodule
